// File: rtl/clock24_time_core_if.sv
// clock24_time_core_if: timebase/button inputs and BCD time outputs of the 24-hour clock core
interface clock24_time_core_if;
  logic en1hz;
  logic sig2hz;
  logic mode_p;
  logic up_p;
  logic [7:0] hour;
  logic [7:0] min;
  logic [7:0] sec;
  logic [2:0] blank;
  logic setting;
  modport master (output en1hz, sig2hz, mode_p, up_p, input hour, min, sec, blank, setting);
  modport slave (input en1hz, sig2hz, mode_p, up_p, output hour, min, sec, blank, setting);
endinterface

// File: rtl/clock24_time_core.sv
// clock24_time_core: packed-BCD 24-hour time-of-day counter with run/set-hour/set-minute mode machine
module clock24_time_core (
  input logic CLK,
  input logic RST,
  clock24_time_core_if.slave bus
);
  typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN} state_t;
  state_t state, nxt;
  logic tick, up;
  function automatic logic [7:0] inc60(input logic [7:0] v);
    return v[3:0] == 4'd9 ? (v[7:4] == 4'd5 ? 8'h00 : {v[7:4] + 4'd1, 4'd0}) : {v[7:4], v[3:0] + 4'd1};
  endfunction
  function automatic logic [7:0] inc24(input logic [7:0] v);
    return v == 8'h23 ? 8'h00 : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction
  // MODE_P has priority: it masks both the seconds tick and the UP pulse in its cycle
  always_comb begin
    nxt = state == RUN ? (bus.mode_p ? SET_HOUR : RUN) :
          state == SET_HOUR ? (bus.mode_p ? SET_MIN : SET_HOUR) :
          state == SET_MIN ? (bus.mode_p ? RUN : SET_MIN) : RUN;
    tick = state == RUN && bus.en1hz && !bus.mode_p;
    up = bus.up_p && !bus.mode_p;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= RUN;
      bus.hour <= 8'h00;
      bus.min <= 8'h00;
      bus.sec <= 8'h00;
      bus.blank <= 3'b000;
      bus.setting <= 1'b0;
    end else begin
      state <= nxt;
      bus.setting <= nxt != RUN;
      bus.blank <= nxt == SET_HOUR ? {bus.sig2hz, 2'b00} : nxt == SET_MIN ? {1'b0, bus.sig2hz, 1'b0} : 3'b000;
      if (state == RUN && bus.mode_p) bus.sec <= 8'h00;
      else if (tick) bus.sec <= inc60(bus.sec);
      if ((tick && bus.sec == 8'h59) || (up && state == SET_MIN)) bus.min <= inc60(bus.min);
      if ((tick && bus.sec == 8'h59 && bus.min == 8'h59) || (up && state == SET_HOUR)) bus.hour <= inc24(bus.hour);
    end
endmodule

// File: tb/tb_clock24_time_core.sv
// tb_clock24_time_core: vector table plus directed sequences and a randomized run against an integer time model
module tb_clock24_time_core;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  clock24_time_core_if bus ();
  clock24_time_core dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;

  typedef struct {
    logic m, u, e, s;
    logic [7:0] h, mi, se;
    logic [2:0] b;
    logic st;
  } vec_t;
  vec_t tv[11];

  int total = 0;
  int bad = 0;
  int mh = 0, mm = 0, ms = 0, mst = 0;
  logic [2:0] mblank = 3'b000;

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, act, exp);
    end
  endtask

  task automatic chk_all(input string n, input logic [7:0] h, input logic [7:0] mi, input logic [7:0] se,
                         input logic [2:0] b, input logic st);
    chk({n, ".hour"}, 32'(bus.hour), 32'(h));
    chk({n, ".min"}, 32'(bus.min), 32'(mi));
    chk({n, ".sec"}, 32'(bus.sec), 32'(se));
    chk({n, ".blank"}, 32'(bus.blank), 32'(b));
    chk({n, ".setting"}, 32'(bus.setting), 32'(st));
  endtask

  task automatic model_reset();
    mh = 0; mm = 0; ms = 0; mst = 0; mblank = 3'b000;
  endtask

  task automatic model_step(input logic m, input logic u, input logic e, input logic s);
    if (m) begin
      if (mst == 0) begin mst = 1; ms = 0; end
      else if (mst == 1) mst = 2;
      else mst = 0;
    end else if (mst == 0 && e) begin
      ms++;
      if (ms == 60) begin
        ms = 0; mm++;
        if (mm == 60) begin mm = 0; mh = (mh + 1) % 24; end
      end
    end else if (mst == 1 && u) mh = (mh + 1) % 24;
    else if (mst == 2 && u) mm = (mm + 1) % 60;
    mblank = mst == 1 ? {s, 2'b00} : mst == 2 ? {1'b0, s, 1'b0} : 3'b000;
  endtask

  task automatic cyc(input logic m, input logic u, input logic e, input logic s);
    @(negedge CLK);
    bus.mode_p = m; bus.up_p = u; bus.en1hz = e; bus.sig2hz = s;
    @(posedge CLK);
    model_step(m, u, e, s);
    #1;
    bus.mode_p = 1'b0; bus.up_p = 1'b0; bus.en1hz = 1'b0;
  endtask

  task automatic sync_reset();
    @(negedge CLK);
    RST = 1'b1;
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
  endtask

  logic [7:0] pat;
  logic legal;

  initial begin
    bus.en1hz = 1'b0; bus.sig2hz = 1'b0; bus.mode_p = 1'b0; bus.up_p = 1'b0;
    tv[0]  = '{0, 0, 1, 0, 8'h00, 8'h00, 8'h01, 3'b000, 1'b0};
    tv[1]  = '{0, 1, 0, 0, 8'h00, 8'h00, 8'h01, 3'b000, 1'b0};
    tv[2]  = '{1, 0, 1, 1, 8'h00, 8'h00, 8'h00, 3'b100, 1'b1};
    tv[3]  = '{0, 1, 0, 0, 8'h01, 8'h00, 8'h00, 3'b000, 1'b1};
    tv[4]  = '{0, 0, 1, 1, 8'h01, 8'h00, 8'h00, 3'b100, 1'b1};
    tv[5]  = '{1, 1, 0, 1, 8'h01, 8'h00, 8'h00, 3'b010, 1'b1};
    tv[6]  = '{0, 1, 0, 0, 8'h01, 8'h01, 8'h00, 3'b000, 1'b1};
    tv[7]  = '{0, 1, 0, 1, 8'h01, 8'h02, 8'h00, 3'b010, 1'b1};
    tv[8]  = '{1, 0, 1, 1, 8'h01, 8'h02, 8'h00, 3'b000, 1'b0};
    tv[9]  = '{0, 0, 1, 0, 8'h01, 8'h02, 8'h01, 3'b000, 1'b0};
    tv[10] = '{0, 0, 0, 1, 8'h01, 8'h02, 8'h01, 3'b000, 1'b0};

    repeat (3) @(posedge CLK);
    #1;
    chk_all("reset", 8'h00, 8'h00, 8'h00, 3'b000, 1'b0);
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < 11; i++) begin
      cyc(tv[i].m, tv[i].u, tv[i].e, tv[i].s);
      chk_all($sformatf("vec%0d", i), tv[i].h, tv[i].mi, tv[i].se, tv[i].b, tv[i].st);
    end

    // asynchronous reset lands between edges and must clear outputs before the next edge
    @(negedge CLK);
    #2 RST = 1'b1;
    model_reset();
    #1;
    chk_all("async_rst", 8'h00, 8'h00, 8'h00, 3'b000, 1'b0);
    @(posedge CLK);
    #1;
    chk_all("rst_hold", 8'h00, 8'h00, 8'h00, 3'b000, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 61; i++) begin
      cyc(0, 0, 1, 0);
      repeat (4) cyc(0, 0, 0, 0);
    end
    chk_all("count61", 8'h00, 8'h01, 8'h01, 3'b000, 1'b0);

    sync_reset();
    cyc(1, 0, 0, 0);
    chk("setflow.enter", 32'(bus.setting), 32'd1);
    repeat (25) cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    chk_all("setflow.hour", 8'h01, 8'h00, 8'h00, 3'b000, 1'b1);
    cyc(1, 0, 0, 0);
    repeat (61) cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    chk_all("setflow.min", 8'h01, 8'h01, 8'h00, 3'b000, 1'b1);
    cyc(1, 0, 0, 0);
    chk_all("setflow.run", 8'h01, 8'h01, 8'h00, 3'b000, 1'b0);

    cyc(1, 0, 0, 0);
    repeat (22) cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    repeat (58) cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    repeat (58) cyc(0, 0, 1, 0);
    chk_all("roll.58", 8'h23, 8'h59, 8'h58, 3'b000, 1'b0);
    cyc(0, 0, 1, 0);
    chk_all("roll.59", 8'h23, 8'h59, 8'h59, 3'b000, 1'b0);
    cyc(0, 0, 1, 0);
    chk_all("roll.wrap", 8'h00, 8'h00, 8'h00, 3'b000, 1'b0);

    cyc(1, 0, 0, 0);
    repeat (12) cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    repeat (34) cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    repeat (56) cyc(0, 0, 1, 0);
    chk_all("coll.pre", 8'h12, 8'h34, 8'h56, 3'b000, 1'b0);
    cyc(1, 0, 1, 0);
    chk_all("coll.mode_en", 8'h12, 8'h34, 8'h00, 3'b000, 1'b1);
    cyc(1, 1, 0, 1);
    chk_all("coll.mode_up", 8'h12, 8'h34, 8'h00, 3'b010, 1'b1);
    cyc(1, 0, 0, 0);

    pat = 8'b10110010;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, pat[i]);
      chk($sformatf("blink.hour%0d", i), 32'(bus.blank), 32'({pat[i], 2'b00}));
    end
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, pat[i]);
      chk($sformatf("blink.min%0d", i), 32'(bus.blank), 32'({1'b0, pat[i], 1'b0}));
    end
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, pat[i]);
      chk($sformatf("blink.run%0d", i), 32'(bus.blank), 32'd0);
    end

    sync_reset();
    for (int i = 0; i < 30000; i++) begin
      cyc(($urandom % 32) == 0, ($urandom % 6) == 0, ($urandom % 4) != 0, 1'($urandom));
      legal = bus.hour[3:0] <= 4'd9 && bus.hour <= 8'h23 && bus.min[3:0] <= 4'd9 && bus.min <= 8'h59
           && bus.sec[3:0] <= 4'd9 && bus.sec <= 8'h59;
      chk("rand.legal", 32'(legal), 32'd1);
      chk("rand.model", {bus.hour, bus.min, bus.sec, 4'(bus.blank), 4'(bus.setting)},
          {bcd(mh), bcd(mm), bcd(ms), 4'(mblank), 4'(mst != 0)});
      if (bad != 0) break;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
